wrn_txtsu_buffer: RTL and testbench

Transmit-timestamp buffer that sits directly downstream of the WR endpoint timestamping logic and upstream of the host driver, mapped at BASE_TXTSU (0x00e1000) on the NIC Wishbone crossbar. It captures one record per transmitted frame, queues it in a synchronous FIFO, and presents the head record through a Wishbone classic slave. It raises a level interrupt to the VIC while records are pending.

---
 rtl/wrn_txtsu_buffer_pkg.sv | 34 +++
 rtl/wrn_txtsu_buffer_if.sv | 21 ++
 rtl/wrn_sync_fifo.sv | 63 ++++++
 rtl/wrn_txtsu_buffer.sv | 134 +++++++++++++
 tb/tb_wrn_txtsu_buffer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wrn_txtsu_buffer_pkg.sv
// Shared types and register-map constants for the WR transmit-timestamp buffer.
package wrn_txtsu_pkg;

  typedef struct packed {
    logic        incorrect;
    logic [4:0]  port_id;
    logic [15:0] frame_id;
    logic [31:0] value;
  } t_txtsu_entry;

  typedef enum logic {
    WB_IDLE,
    WB_ACK
  } t_wb_state;

  localparam logic [2:0] c_adr_csr    = 3'd0;
  localparam logic [2:0] c_adr_ovf    = 3'd1;
  localparam logic [2:0] c_adr_ts_val = 3'd2;
  localparam logic [2:0] c_adr_ts_id  = 3'd3;
  localparam logic [2:0] c_adr_pop    = 3'd4;

  localparam int unsigned c_csr_irq_en   = 0;
  localparam int unsigned c_csr_empty    = 1;
  localparam int unsigned c_csr_full     = 2;
  localparam int unsigned c_csr_used_lsb = 8;
  localparam logic [31:0] c_csr_used_mask = 32'h0000_1F00;

  localparam logic [15:0] c_ovf_max = 16'hFFFF;

  function automatic logic [31:0] ts_id_word(input t_txtsu_entry e);
    return {e.incorrect, 10'd0, e.port_id, e.frame_id};
  endfunction

endpackage

// File: rtl/wrn_txtsu_buffer_if.sv
// Wishbone classic bus between the host crossbar and the timestamp buffer.
interface wrn_txtsu_buffer_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [2:0]  adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/wrn_sync_fifo.sv
// Generic show-ahead synchronous FIFO; push and pop may coincide even when full.
module wrn_sync_fifo #(
  parameter int unsigned g_width = 8,
  parameter int unsigned g_depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [g_width-1:0]       data_i,
  output logic [g_width-1:0]       data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(g_depth):0] count_o
);
  localparam int unsigned c_aw = $clog2(g_depth);
  localparam logic [c_aw:0] c_full = (c_aw + 1)'(g_depth);

  logic [g_width-1:0] mem_q [g_depth];
  logic [c_aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]      count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == c_full);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the concurrent push needs, so a full FIFO accepts both.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + c_aw'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + c_aw'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (c_aw + 1)'(1);
      2'b01:   count_d = count_q - (c_aw + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wrn_txtsu_buffer.sv
// TX timestamp buffer: queues endpoint timestamp records and exposes the head via Wishbone.
// Optional overflow counter built when WRN_TXTSU_OVF_CNT_EN is defined.
module wrn_txtsu_buffer
  import wrn_txtsu_pkg::*;
#(
  parameter int unsigned g_depth = 16
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_i,
  input  logic              ts_valid_i,
  input  logic [31:0]       ts_value_i,
  input  logic [4:0]        ts_port_id_i,
  input  logic [15:0]       ts_frame_id_i,
  input  logic              ts_incorrect_i,
  wrn_txtsu_buffer_if.slave wb,
  output logic              irq_o
);
  localparam int unsigned c_cnt_w = $clog2(g_depth) + 1;

  t_wb_state          state_q, state_d;
  logic               req, wr_req;
  logic               csr_wr, pop_wr;
  logic [31:0]        dat_q, dat_d;
  logic               irq_en_q, irq_en_d;
  logic               irq_q;
  t_txtsu_entry       push_entry, head;
  logic               fifo_full, fifo_empty;
  logic [c_cnt_w-1:0] fifo_count;
  logic [31:0]        used_word, ovf_word;
  logic               unused_ok;

  assign push_entry = '{incorrect: ts_incorrect_i, port_id: ts_port_id_i,
                        frame_id: ts_frame_id_i, value: ts_value_i};

  wrn_sync_fifo #(
    .g_width($bits(t_txtsu_entry)),
    .g_depth(g_depth)
  ) u_fifo (
    .clk_i  (clk_sys_i),
    .rst_i  (rst_sys_i),
    .push_i (ts_valid_i),
    .pop_i  (pop_wr),
    .data_i (push_entry),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  // Requests are only accepted while idle, so a held strobe is acked every other cycle.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (wb.cyc_i && wb.stb_i) begin
          req     = 1'b1;
          state_d = WB_ACK;
        end
      end
      WB_ACK:  state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  assign wr_req = req & wb.we_i;
  assign csr_wr = wr_req && (wb.adr_i == c_adr_csr);
  assign pop_wr = wr_req && (wb.adr_i == c_adr_pop);

  assign irq_en_d  = csr_wr ? wb.dat_i[c_csr_irq_en] : irq_en_q;
  assign used_word = (32'(fifo_count) << c_csr_used_lsb) & c_csr_used_mask;

  always_comb begin
    dat_d = '0;
    if (req && !wb.we_i) begin
      unique case (wb.adr_i)
        c_adr_csr: begin
          dat_d               = used_word;
          dat_d[c_csr_irq_en] = irq_en_q;
          dat_d[c_csr_empty]  = fifo_empty;
          dat_d[c_csr_full]   = fifo_full;
        end
        c_adr_ovf:    dat_d = ovf_word;
        c_adr_ts_val: if (!fifo_empty) dat_d = head.value;
        c_adr_ts_id:  if (!fifo_empty) dat_d = ts_id_word(head);
        default:      dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q  <= WB_IDLE;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dat_q    <= dat_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q & ~fifo_empty;
    end
  end

  assign wb.ack_o = (state_q == WB_ACK);
  assign wb.dat_o = dat_q;
  assign irq_o    = irq_q;

`ifdef WRN_TXTSU_OVF_CNT_EN
  logic [15:0] ovf_q, ovf_d;
  logic        ovf_wr, drop;

  assign ovf_wr = wr_req && (wb.adr_i == c_adr_ovf);
  assign drop   = ts_valid_i && fifo_full && !pop_wr;

  // Clear is applied before the increment so a coincident drop leaves a count of 1.
  always_comb begin
    ovf_d = ovf_wr ? '0 : ovf_q;
    if (drop && (ovf_d != c_ovf_max)) ovf_d = ovf_d + 16'd1;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) ovf_q <= '0;
    else           ovf_q <= ovf_d;
  end

  assign ovf_word = {16'd0, ovf_q};
`else
  assign ovf_word = '0;
`endif

  assign unused_ok = ^{wb.sel_i, wb.dat_i};

endmodule

// File: tb/tb_wrn_txtsu_buffer.sv
// Self-checking bench for wrn_txtsu_buffer against a queue-based model of the register map.
module tb_wrn_txtsu_buffer;

  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  port;
    logic [15:0] frame;
    logic        inc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ts_valid;
  logic [31:0] ts_value;
  logic [4:0]  ts_port;
  logic [15:0] ts_frame;
  logic        ts_inc;
  logic        irq;

  wrn_txtsu_buffer_if wb_bus ();

  wrn_txtsu_buffer #(.g_depth(DEPTH)) dut (
    .clk_sys_i     (clk),
    .rst_sys_i     (rst),
    .ts_valid_i    (ts_valid),
    .ts_value_i    (ts_value),
    .ts_port_id_i  (ts_port),
    .ts_frame_id_i (ts_frame),
    .ts_incorrect_i(ts_inc),
    .wb            (wb_bus.slave),
    .irq_o         (irq)
  );

  always #8 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  rec_t q[$];
  int   ovf    = 0;
  bit   irq_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.value = $urandom;
    r.port  = 5'($urandom);
    r.frame = 16'($urandom);
    r.inc   = 1'($urandom);
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    logic [31:0] v;
    bit full, empty;
    v     = '0;
    empty = (q.size() == 0);
    full  = (q.size() == DEPTH);
    case (a)
      3'd0: v = {19'd0, 5'(q.size()), 5'd0, full, empty, irq_en};
`ifdef WRN_TXTSU_OVF_CNT_EN
      3'd1: v = 32'(ovf);
`endif
      3'd2: if (!empty) v = q[0].value;
      3'd3: if (!empty) v = {q[0].inc, 10'd0, q[0].port, q[0].frame};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Transfer semantics: pop if anything is queued; push accepted if room or popping.
  task automatic model_cycle(input bit push, input rec_t r, input bit pop, input bit ovf_clr);
    bit pop_eff, acc;
    pop_eff = pop && (q.size() > 0);
    acc     = push && ((q.size() < DEPTH) || pop_eff);
    if (ovf_clr) ovf = 0;
    if (pop_eff) void'(q.pop_front());
    if (acc) q.push_back(r);
    else if (push && ovf < 65535) ovf++;
  endtask

  // One clock: optionally a bus request and/or a timestamp strobe, then check the outcome.
  task automatic cycle(input bit bus, input bit we, input logic [2:0] adr,
                       input logic [31:0] dat, input bit push, input rec_t r);
    logic [31:0] exp_rd;
    bit exp_irq;
    exp_rd  = exp_read(adr);
    exp_irq = irq_en && (q.size() > 0);
    wb_bus.cyc_i = bus;
    wb_bus.stb_i = bus;
    wb_bus.we_i  = we;
    wb_bus.adr_i = adr;
    wb_bus.dat_i = dat;
    ts_valid = push;
    ts_value = r.value;
    ts_port  = r.port;
    ts_frame = r.frame;
    ts_inc   = r.inc;
    @(posedge clk);
    #1;
    wb_bus.cyc_i = 1'b0;
    wb_bus.stb_i = 1'b0;
    wb_bus.we_i  = 1'b0;
    ts_valid     = 1'b0;
    check("irq", irq, exp_irq);
    check("ack", wb_bus.ack_o, bus);
    if (bus && !we) check($sformatf("rd%0d", adr), wb_bus.dat_o, exp_rd);
    if (bus && we && adr == 3'd0) irq_en = dat[0];
    model_cycle(push, r, bus && we && adr == 3'd4, bus && we && adr == 3'd1);
  endtask

  task automatic idle();
    rec_t r;
    r = '{default: '0};
    cycle(0, 0, 3'd0, 32'd0, 0, r);
  endtask

  task automatic wb_rd(input logic [2:0] adr);
    rec_t r;
    r = '{default: '0};
    cycle(1, 0, adr, 32'd0, 0, r);
    idle();
  endtask

  task automatic wb_wr(input logic [2:0] adr, input logic [31:0] dat, input bit push, input rec_t r);
    rec_t z;
    z = '{default: '0};
    cycle(1, 1, adr, dat, push, r);
    idle();
  endtask

  task automatic push_rec(input rec_t r);
    cycle(0, 0, 3'd0, 32'd0, 1, r);
  endtask

  initial begin
    rec_t r, z;
    logic [2:0] a;
    z = '{default: '0};
    rst = 1'b1;
    ts_valid = 1'b0; ts_value = '0; ts_port = '0; ts_frame = '0; ts_inc = 1'b0;
    wb_bus.cyc_i = 1'b0; wb_bus.stb_i = 1'b0; wb_bus.we_i = 1'b0;
    wb_bus.adr_i = '0; wb_bus.sel_i = 4'hF; wb_bus.dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb_bus.ack_o, 1'b0);
    check("rst_dat", wb_bus.dat_o, 32'd0);
    check("rst_irq", irq, 1'b0);
    rst = 1'b0;

    wb_rd(3'd0);
    check("csr_reset_const", exp_read(3'd0), 32'h0000_0002);

    // First record with IRQ enabled.
    wb_wr(3'd0, 32'd1, 0, z);
    r.value = 32'hDEADBEE1; r.port = 5'd3; r.frame = 16'h1234; r.inc = 1'b1;
    push_rec(r);
    idle();
    check("irq_up", irq, 1'b1);
    wb_rd(3'd2);
    wb_rd(3'd3);
    wb_rd(3'd0);

    wb_wr(3'd4, 32'd0, 0, z);
    wb_rd(3'd0);
    idle();
    check("irq_down", irq, 1'b0);
    wb_rd(3'd2);

    // Fill and overflow.
    for (int i = 0; i < DEPTH + 3; i++) push_rec(rand_rec());
    wb_rd(3'd0);
    wb_rd(3'd1);
    wb_rd(3'd2);
    wb_rd(3'd3);

    // Push coincident with acked POP while full.
    wb_wr(3'd4, 32'd0, 1, rand_rec());
    wb_rd(3'd0);
    wb_rd(3'd1);

    // OVF clear coincident with a drop.
    wb_wr(3'd1, 32'd0, 1, rand_rec());
    wb_rd(3'd1);

    for (int i = 0; i < DEPTH + 1; i++) begin
      wb_wr(3'd4, 32'd0, 0, z);
      wb_rd(3'd2);
      wb_rd(3'd3);
    end
    wb_rd(3'd0);

    // Held strobe: ack on alternate cycles.
    wb_bus.cyc_i = 1'b1; wb_bus.stb_i = 1'b1; wb_bus.we_i = 1'b0; wb_bus.adr_i = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("held_ack%0d", i), wb_bus.ack_o, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    wb_bus.cyc_i = 1'b0; wb_bus.stb_i = 1'b0;
    idle();

    // Randomized mix of strobes and bus traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: push_rec(rand_rec());
        4: wb_wr(3'd4, $urandom, 1'($urandom), rand_rec());
        5: wb_rd(3'($urandom));
        6: wb_wr(3'd0, $urandom, 1'($urandom), rand_rec());
        7: wb_wr(3'd1, $urandom, 1'($urandom), rand_rec());
        8: begin
          a = 3'($urandom_range(5, 7));
          if ($urandom_range(0, 1) == 0) a = 3'd2;
          wb_wr(a, $urandom, 0, z);
          wb_rd(3'd0);
        end
        default: idle();
      endcase
    end
    for (int a2 = 0; a2 < 8; a2++) wb_rd(3'(a2));

    // Reset during a pending read with a strobe present.
    if (q.size() == 0) push_rec(rand_rec());
    rst = 1'b1;
    wb_bus.cyc_i = 1'b1; wb_bus.stb_i = 1'b1; wb_bus.we_i = 1'b0; wb_bus.adr_i = 3'd2;
    ts_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ack", wb_bus.ack_o, 1'b0);
    check("rst_mid_dat", wb_bus.dat_o, 32'd0);
    check("rst_mid_irq", irq, 1'b0);
    rst = 1'b0;
    wb_bus.cyc_i = 1'b0; wb_bus.stb_i = 1'b0; ts_valid = 1'b0;
    q.delete();
    ovf = 0;
    irq_en = 1'b0;
    wb_rd(3'd0);
    wb_rd(3'd2);
    wb_rd(3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
